parking_gate_controller: RTL

//  Owns the free-space count and both barrier gates of the lot.

---
 rtl/parking_pkg.sv | 15 +
 rtl/parking_gate_controller_if.sv | 30 +++
 rtl/gate_fsm.sv | 85 ++++++++
 rtl/parking_gate_controller.sv | 89 ++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared constants and gate FSM state encoding for the parking lot controller
package parking_pkg;

    localparam int CNT_W            = 8;
    localparam int DEF_CAPACITY     = 200;
    localparam int DEF_GATE_TIMEOUT = 16;
    localparam int DEF_TMR_W        = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_COMMIT = 2'd2
    } gate_state_t;

endpackage

// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - request, sensor, gate and count signals of the parking controller
interface parking_gate_controller_if;
  import parking_pkg::*;

  logic             entry;
  logic             enable;
  logic             entry_pass;
  logic             exit_req;
  logic             exit_pass;
  logic [CNT_W-1:0] parking_capacity;
  logic             gate_entry_open;
  logic             gate_exit_open;
  logic             entry_denied;
  logic [1:0]       gate_timeout;
  logic             count_err;

  // slave: the controller; master: the lot environment (sensors, entry_checker)
  modport slave (
    input  entry, enable, entry_pass, exit_req, exit_pass,
    output parking_capacity, gate_entry_open, gate_exit_open,
           entry_denied, gate_timeout, count_err
  );

  modport master (
    output entry, enable, entry_pass, exit_req, exit_pass,
    input  parking_capacity, gate_entry_open, gate_exit_open,
           entry_denied, gate_timeout, count_err
  );

endinterface

// File: rtl/gate_fsm.sv
// rtl/gate_fsm.sv - one barrier gate: request edge detect, open timer, commit strobe
module gate_fsm
  import parking_pkg::*;
#(
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int TMR_W        = DEF_TMR_W,
  parameter bit HAS_DENY     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic grant,
  input  logic pass,
  output logic gate_open,
  output logic commit,
  output logic timeout,
  output logic denied
);

  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(GATE_TIMEOUT);

  gate_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             armed_q;
  logic             timeout_q, timeout_d;
  logic             denied_q, denied_d;
  logic             rise;

  // armed_q means "request was low last cycle"; clearing it at reset keeps a
  // request that is still held across reset from reopening the gate.
  assign rise = req & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      armed_q   <= 1'b0;
      timeout_q <= 1'b0;
      denied_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      armed_q   <= ~req;
      timeout_q <= timeout_d;
      denied_q  <= denied_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    denied_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          if (grant) begin
            state_d = ST_OPEN;
            timer_d = TMR_INIT;
          end else begin
            denied_d = HAS_DENY;
          end
        end
      end
      ST_OPEN: begin
        if (pass) begin
          state_d = ST_COMMIT;
        end else if (timer_q == '0) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign gate_open = (state_q == ST_OPEN);
  assign commit    = (state_q == ST_COMMIT);
  assign timeout   = timeout_q;
  assign denied    = denied_q;

endmodule

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - free-space counter and the entry/exit gate FSMs of the lot
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int TMR_W        = DEF_TMR_W
) (
  input logic                     clk,
  input logic                     rst_n,
  parking_gate_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] cap_q;
  logic             count_err_q;
  logic             entry_commit, exit_commit;
  logic             entry_to, exit_to;
  logic             entry_open, exit_open;
  logic             entry_denied;
  logic             exit_grant;
  logic             exit_denied_unused;

  // An exit only makes sense while at least one car is inside.
  assign exit_grant = (cap_q != CAP_V);

  gate_fsm #(
    .GATE_TIMEOUT (GATE_TIMEOUT),
    .TMR_W        (TMR_W),
    .HAS_DENY     (1'b1)
  ) u_entry_gate (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.entry),
    .grant     (bus.enable),
    .pass      (bus.entry_pass),
    .gate_open (entry_open),
    .commit    (entry_commit),
    .timeout   (entry_to),
    .denied    (entry_denied)
  );

  gate_fsm #(
    .GATE_TIMEOUT (GATE_TIMEOUT),
    .TMR_W        (TMR_W),
    .HAS_DENY     (1'b0)
  ) u_exit_gate (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.exit_req),
    .grant     (exit_grant),
    .pass      (bus.exit_pass),
    .gate_open (exit_open),
    .commit    (exit_commit),
    .timeout   (exit_to),
    .denied    (exit_denied_unused)
  );

  // Simultaneous entry and exit commits cancel; a commit that would leave
  // 0..CAPACITY is dropped and flagged instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= CAP_V;
      count_err_q <= 1'b0;
    end else begin
      count_err_q <= 1'b0;
      case ({entry_commit, exit_commit})
        2'b10: begin
          if (cap_q == '0) count_err_q <= 1'b1;
          else             cap_q       <= cap_q - CNT_W'(1);
        end
        2'b01: begin
          if (cap_q == CAP_V) count_err_q <= 1'b1;
          else                cap_q       <= cap_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.parking_capacity = cap_q;
  assign bus.gate_entry_open  = entry_open;
  assign bus.gate_exit_open   = exit_open;
  assign bus.entry_denied     = entry_denied;
  assign bus.gate_timeout     = {exit_to, entry_to};
  assign bus.count_err        = count_err_q;

endmodule
